serial_addsub: RTL and testbench



---
 rtl/serial_addsub.sv | 104 ++++++++++
 tb/tb_serial_addsub.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, one bit per clock, LSB first.
// Subtraction is available only when SERIAL_ADDSUB_SUB_EN is defined; otherwise sub_i is ignored.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit  = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] MsbInBit = CntW'(WIDTH - 2);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, result_q;
  logic [CntW-1:0]  cnt_q;
  logic             c_q, c_msb_q, busy_q, done_q, cout_q, ovf_q;
  logic             sub_eff, s_bit, c_next;

`ifdef SERIAL_ADDSUB_SUB_EN
  assign sub_eff = sub_i;
`else
  // Adder-only build: the port stays, its value is masked off.
  assign sub_eff = sub_i & 1'b0;
`endif

  assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      c_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            a_q     <= a_i;
            b_q     <= sub_eff ? ~b_i : b_i;
            c_q     <= sub_eff;
            cnt_q   <= '0;
            sum_q   <= '0;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_next;
          sum_q <= {s_bit, sum_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CntW'(1);
          // Carry into the MSB, kept for the signed-overflow test.
          if (cnt_q == MsbInBit) c_msb_q <= c_next;
          if (cnt_q == LastBit) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= {s_bit, sum_q[WIDTH-1:1]};
            cout_q   <= c_next;
            ovf_q    <= c_msb_q ^ c_next;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub against an arithmetic reference model.
module tb_serial_addsub;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .sub_i    (sub),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .cout_o   (cout),
    .ovf_o    (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, unsigned for result/carry, signed range for overflow.
  function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                input logic msub, output logic [WIDTH-1:0] r,
                                output logic co, output logic ov);
    longint ua, ub, sa, sb, res, sr, modv;
    logic   eff;
`ifdef SERIAL_ADDSUB_SUB_EN
    eff = msub;
`else
    eff = 1'b0 & msub;
`endif
    modv = longint'(1) << WIDTH;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = ma[WIDTH-1] ? ua - modv : ua;
    sb = mb[WIDTH-1] ? ub - modv : ub;
    if (eff) begin
      res = ua - ub;
      co  = (ua >= ub);
      sr  = sa - sb;
    end else begin
      res = ua + ub;
      co  = (res >= modv);
      sr  = sa + sb;
    end
    r  = res[WIDTH-1:0];
    ov = (sr < -(modv / 2)) || (sr > (modv / 2) - 1);
  endfunction

  // Stimulus only: issues one operation, returns edges-to-done and busy cycles seen.
  task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic os,
                       output int lat, output int nbusy, output logic tout);
    @(negedge clk);
    start = 1'b1; a = oa; b = ob; sub = os;
    @(negedge clk);
    start = 1'b0;
    lat = 0; nbusy = 0;
    while (done !== 1'b1 && lat < int'(WIDTH) + 4) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    tout = (done !== 1'b1);
  endtask

  task automatic test_reset();
    int lat, nb;
    rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, cout, ovf, result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b ovf=%b result=%h, want all 0",
               busy, done, cout, ovf, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; nb = 0;
    while (done !== 1'b1 && lat < int'(WIDTH) + 4) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != int'(WIDTH) || nb != int'(WIDTH)) begin
      errors++;
      $display("FAIL reset_first_latency: got lat=%0d busy=%0d, want %0d/%0d", lat, nb, WIDTH,
               WIDTH);
    end
    checks++;
    if (result !== 8'h46) begin
      errors++;
      $display("FAIL reset_first_result: got %h, want 46", result);
    end
  endtask

  task automatic test_carry_chain();
    int lat, nb;
    logic to;
    do_op(8'h0F, 8'h01, 1'b0, lat, nb, to);
    checks++;
    if (to || {result, cout, ovf} !== {8'h10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL carry_0f_01: got %h c=%b v=%b to=%b, want 10 c=0 v=0", result, cout, ovf, to);
    end
    do_op(8'hFF, 8'h01, 1'b0, lat, nb, to);
    checks++;
    if (to || {result, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL carry_ff_01: got %h c=%b v=%b to=%b, want 00 c=1 v=0", result, cout, ovf, to);
    end
  endtask

  task automatic test_overflow();
    int lat, nb;
    logic to;
    logic [WIDTH-1:0] ra, rb, er;
    logic ec, ev;
    do_op(8'h7F, 8'h01, 1'b0, lat, nb, to);
    checks++;
    if (to || {result, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_7f_01: got %h c=%b v=%b to=%b, want 80 c=0 v=1", result, cout, ovf, to);
    end
    ra = WIDTH'($urandom); rb = WIDTH'($urandom);
    @(negedge clk);
    start = 1'b1; a = ra; b = rb; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      checks++;
      if ({result, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL ovf_hold cycle %0d: got %h c=%b v=%b, want 80 c=0 v=1", i, result, cout,
                 ovf);
      end
      @(negedge clk);
    end
    model(ra, rb, 1'b0, er, ec, ev);
    checks++;
    if (done !== 1'b1 || {result, cout, ovf} !== {er, ec, ev}) begin
      errors++;
      $display("FAIL ovf_next_op: got done=%b %h c=%b v=%b, want done=1 %h c=%b v=%b", done,
               result, cout, ovf, er, ec, ev);
    end
  endtask

  task automatic test_subtract();
    int lat, nb;
    logic to;
    logic [WIDTH-1:0] er;
    logic ec, ev;
    do_op(8'h05, 8'h07, 1'b1, lat, nb, to);
    model(8'h05, 8'h07, 1'b1, er, ec, ev);
    checks++;
    if (to || {result, cout, ovf} !== {er, ec, ev}) begin
      errors++;
      $display("FAIL sub_05_07: got %h c=%b v=%b, want %h c=%b v=%b", result, cout, ovf, er, ec,
               ev);
    end
    do_op(8'h80, 8'h01, 1'b1, lat, nb, to);
    model(8'h80, 8'h01, 1'b1, er, ec, ev);
    checks++;
    if (to || {result, cout, ovf} !== {er, ec, ev}) begin
      errors++;
      $display("FAIL sub_80_01: got %h c=%b v=%b, want %h c=%b v=%b", result, cout, ovf, er, ec,
               ev);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < int'(WIDTH) + 4) begin
      if (lat == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat != int'(WIDTH) || {result, cout, ovf} !== {8'h10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d %h c=%b v=%b, want lat=%0d 10 c=0 v=0", lat, result,
               cout, ovf, WIDTH);
    end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    logic [WIDTH-1:0] ra, rb, er;
    logic ec, ev;
    int n;
    ra = WIDTH'($urandom); rb = WIDTH'($urandom);
    model(ra, rb, 1'b0, er, ec, ev);
    @(negedge clk);
    start = 1'b1; a = ra; b = rb; sub = 1'b0;
    for (int i = 0; i < 5 * (int'(WIDTH) + 1); i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        hits.push_back(i);
        checks++;
        if ({result, cout, ovf} !== {er, ec, ev}) begin
          errors++;
          $display("FAIL b2b_result: got %h c=%b v=%b, want %h c=%b v=%b", result, cout, ovf, er,
                   ec, ev);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (hits.size() < 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, want >= 4", hits.size());
    end
    for (int i = 1; i < hits.size(); i++) begin
      checks++;
      if (hits[i] - hits[i-1] != int'(WIDTH) + 1) begin
        errors++;
        $display("FAIL b2b_period: got %0d, want %0d", hits[i] - hits[i-1], WIDTH + 1);
      end
    end
    n = 0;
    while ((busy === 1'b1 || done === 1'b1) && n < 2 * int'(WIDTH)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset_mid();
    int lat, nb, seen;
    logic to;
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, cout, ovf, result} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got busy=%b done=%b cout=%b ovf=%b result=%h, want all 0",
               busy, done, cout, ovf, result);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    rst_n = 1'b1;
    repeat (int'(WIDTH) + 2) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d active cycles result=%h, want 0 and 00", seen,
               result);
    end
    do_op(8'h12, 8'h34, 1'b0, lat, nb, to);
    checks++;
    if (to || result !== 8'h46) begin
      errors++;
      $display("FAIL reset_mid_restart: got %h to=%b, want 46", result, to);
    end
  endtask

  task automatic test_random();
    int lat, nb;
    logic to;
    logic [WIDTH-1:0] ra, rb, er;
    logic rs, ec, ev;
    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, lat, nb, to);
      model(ra, rb, rs, er, ec, ev);
      checks++;
      if (to || lat != int'(WIDTH) || nb != int'(WIDTH) || {result, cout, ovf} !== {er, ec, ev})
      begin
        errors++;
        $display("FAIL random %0d (%h %s %h): got %h c=%b v=%b lat=%0d busy=%0d, want %h c=%b v=%b",
                 i, ra, rs ? "-" : "+", rb, result, cout, ovf, lat, nb, er, ec, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
